// File: rtl/stride_yield_gen_pkg.sv
// rtl/stride_yield_gen_pkg.sv - shared constants and FSM state type for stride_yield_gen
package stride_yield_gen_pkg;

    localparam int GEN_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } gen_state_t;

endpackage

// File: rtl/stride_yield_gen_if.sv
// rtl/stride_yield_gen_if.sv - control inputs and tuple stream between host and generator
import stride_yield_gen_pkg::*;

interface stride_yield_gen_if #(
    parameter int WIDTH = GEN_WIDTH
);
    logic                    start;
    logic signed [WIDTH-1:0] base;
    logic signed [WIDTH-1:0] step;
    logic signed [WIDTH-1:0] count;
    logic                    ready;
    logic                    valid;
    logic signed [WIDTH-1:0] out0;
    logic signed [WIDTH-1:0] out1;
    logic                    done;

    modport master (
        output start, base, step, count, ready,
        input  valid, out0, out1, done
    );

    modport slave (
        input  start, base, step, count, ready,
        output valid, out0, out1, done
    );
endinterface

// File: rtl/stride_yield_gen_out_reg.sv
// rtl/stride_yield_gen_out_reg.sv - output tuple register; doubles as the base+i*step accumulator
import stride_yield_gen_pkg::*;

module yield_out_reg #(
    parameter int WIDTH = GEN_WIDTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_out0,
    input  logic [WIDTH-1:0] i_out1,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_out0,
    output logic [WIDTH-1:0] o_out1
);

    logic             r_valid;
    logic [WIDTH-1:0] r_out0;
    logic [WIDTH-1:0] r_out1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_out0  <= '0;
            r_out1  <= '0;
        end else if (i_load) begin
            r_valid <= i_valid;
            r_out0  <= i_out0;
            r_out1  <= i_out1;
        end
    end

    assign o_valid = r_valid;
    assign o_out0  = r_out0;
    assign o_out1  = r_out1;

endmodule

// File: rtl/stride_yield_gen.sv
// rtl/stride_yield_gen.sv - yields COUNT tuples (i, base + i*step) over valid/ready, then done
import stride_yield_gen_pkg::*;

module stride_yield_gen #(
    parameter int WIDTH     = GEN_WIDTH,
    parameter int IDX_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    stride_yield_gen_if.slave     bus
);

    gen_state_t              r_state;
    logic [WIDTH-1:0]        r_step;
    logic signed [WIDTH-1:0] r_count;
    logic [IDX_WIDTH-1:0]    r_idx;
    logic                    r_done;

    logic             w_valid;
    logic [WIDTH-1:0] w_out0;
    logic [WIDTH-1:0] w_out1;
    logic             w_accept;
    logic             w_last;
    logic             w_count_pos;
    logic             w_load;
    logic             w_ld_valid;
    logic [WIDTH-1:0] w_ld_out0;
    logic [WIDTH-1:0] w_ld_out1;

    assign w_accept    = w_valid & bus.ready;
    assign w_count_pos = $signed(bus.count) > 0;
    // r_idx is the index currently presented; last when idx+1 reaches the latched count
    assign w_last      = (r_idx + IDX_WIDTH'(1)) == IDX_WIDTH'(r_count);

    always_comb begin
        w_load     = 1'b0;
        w_ld_valid = 1'b0;
        w_ld_out0  = '0;
        w_ld_out1  = '0;
        if (bus.start) begin
            w_load     = 1'b1;
            w_ld_valid = w_count_pos;
            w_ld_out1  = bus.base;
        end else if (r_state == ST_EMIT && w_accept) begin
            w_load = 1'b1;
            if (w_last) begin
                w_ld_out0 = w_out0;
                w_ld_out1 = w_out1;
            end else begin
                w_ld_valid = 1'b1;
                w_ld_out0  = WIDTH'(r_idx + IDX_WIDTH'(1));
                w_ld_out1  = w_out1 + r_step;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_step  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_done  <= 1'b0;
        end else if (bus.start) begin
            r_step  <= bus.step;
            r_count <= bus.count;
            r_idx   <= '0;
            r_state <= w_count_pos ? ST_EMIT : ST_DONE;
            r_done  <= !w_count_pos;
        end else begin
            case (r_state)
                ST_EMIT: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_idx <= r_idx + IDX_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    yield_out_reg #(.WIDTH(WIDTH)) u_out_reg (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_load  (w_load),
        .i_valid (w_ld_valid),
        .i_out0  (w_ld_out0),
        .i_out1  (w_ld_out1),
        .o_valid (w_valid),
        .o_out0  (w_out0),
        .o_out1  (w_out1)
    );

    assign bus.valid = w_valid;
    assign bus.out0  = w_out0;
    assign bus.out1  = w_out1;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_stride_yield_gen.sv
// tb/tb_stride_yield_gen.sv - randomized and directed bench against a tuple-list reference model
module tb_stride_yield_gen;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] v;
    } tup_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stride_yield_gen_if #(.WIDTH(32)) bus ();

    stride_yield_gen #(.WIDTH(32), .IDX_WIDTH(32)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    tup_t exp_q[$];
    logic m_done = 1'b0;
    logic m_zero = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: a start expands into the full list of expected tuples; accepts pop it
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            m_done = 1'b0;
            m_zero = 1'b1;
        end else if (bus.start) begin
            int cnt;
            cnt = $signed(bus.count);
            exp_q.delete();
            for (int k = 0; k < cnt; k++)
                exp_q.push_back({32'(k), bus.base + 32'(k) * bus.step});
            m_done = (cnt <= 0);
            m_zero = 1'b0;
        end else if (exp_q.size() > 0 && bus.ready) begin
            void'(exp_q.pop_front());
            if (exp_q.size() == 0) m_done = 1'b1;
            m_zero = 1'b0;
        end
        #1;
        chk("valid", 32'(bus.valid), 32'(exp_q.size() > 0));
        chk("done", 32'(bus.done), 32'(m_done));
        if (exp_q.size() > 0) begin
            chk("out0", bus.out0, exp_q[0].i);
            chk("out1", bus.out1, exp_q[0].v);
        end else if (m_zero) begin
            chk("out0_rst", bus.out0, 32'd0);
            chk("out1_rst", bus.out1, 32'd0);
        end
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] s, input logic [31:0] c);
        bus.start = 1'b1;
        bus.base  = b;
        bus.step  = s;
        bus.count = c;
        tick();
        bus.start = 1'b0;
        bus.base  = $urandom;
        bus.step  = $urandom;
        bus.count = $urandom;
    endtask

    // mode 0: ready high; mode 1: ready pattern 1,0,0,1
    task automatic drain(input int mode, input int bound);
        int ph;
        ph = 0;
        while (exp_q.size() > 0 && ph < bound) begin
            bus.ready = (mode == 0) || (ph % 4 == 0) || (ph % 4 == 3);
            tick();
            ph++;
        end
        chk("drain_bound", 32'(exp_q.size()), 32'd0);
        bus.ready = 1'b1;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base  = '0;
        bus.step  = '0;
        bus.count = '0;
        bus.ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        do_start(32'd5, 32'd3, 32'd4);
        drain(0, 20);
        do_start(32'd5, 32'd3, 32'd4);
        drain(1, 40);
        do_start(32'd9, 32'd1, 32'd0);
        tick();
        do_start(32'd9, 32'd1, -32'sd2);
        tick();
        do_start(32'h7FFF_FFFF, 32'd1, 32'd2);
        drain(0, 20);

        bus.ready = 1'b1;
        do_start(32'd5, 32'd3, 32'd4);
        tick();
        do_start(32'd100, -32'sd1, 32'd2);
        drain(0, 20);

        do_start(32'd7, 32'd2, 32'd6);
        tick();
        rst = 1'b1;
        tick();
        do_start(32'd1, 32'd1, 32'd5);
        rst = 1'b0;
        tick();
        tick();

        for (int cyc = 0; cyc < 600; cyc++) begin
            rst       = ($urandom % 64) == 0;
            bus.ready = ($urandom % 4) != 0;
            if (($urandom % ((exp_q.size() > 0) ? 20 : 6)) == 0) begin
                bus.start = 1'b1;
                bus.base  = $urandom;
                bus.step  = ($urandom % 2) ? $urandom : 32'($urandom_range(0, 9)) - 32'd4;
                bus.count = 32'($urandom_range(0, 12)) - 32'd2;
            end else begin
                bus.start = 1'b0;
                bus.base  = $urandom;
                bus.count = $urandom;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
